x_micro_scope_ctrl: RTL

Sequencer that drives one `x_micro_scope` capture/readout cycle. It arms on request, evaluates a masked trigger on the probed data bus, and pulses the scope start. It then waits for the 2048-sample capture to finish, reads the capture RAM back in address order and serialises each 32-bit word into bytes on a valid/ready stream. It sits between the host command path (UART/register decode) and the scope instance.

---
 rtl/x_micro_scope_pkg.sv | 20 ++
 rtl/x_micro_scope_ctrl_if.sv | 29 ++
 rtl/x_micro_scope_ser.sv | 61 ++++++
 rtl/x_micro_scope_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/x_micro_scope_pkg.sv
// Shared definitions for the x_micro_scope capture/readout sequencer.
//   SCOPE_ADDR_W / SCOPE_DATA_W / SCOPE_DEPTH : scope RAM geometry
//   scope_ctrl_state_t                        : sequencer FSM states
package x_micro_scope_pkg;

  localparam int unsigned SCOPE_ADDR_W = 11;
  localparam int unsigned SCOPE_DATA_W = 32;
  localparam int unsigned SCOPE_DEPTH  = 1 << SCOPE_ADDR_W;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StStart,
    StCapture,
    StRdReq,
    StRdLat,
    StSend
  } scope_ctrl_state_t;

endpackage

// File: rtl/x_micro_scope_ctrl_if.sv
// Bus bundle between the sequencer, the scope instance and the byte sink.
//   Scope side : start, busy, ren, raddr, rdata (rdata valid the cycle after ren)
//   Stream side: tx_data, tx_valid, tx_ready (valid/ready byte stream)
// master = sequencer view, slave = scope + byte sink view.
interface x_micro_scope_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 11
) ();

  logic              start;
  logic              busy;
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output start, ren, raddr, tx_data, tx_valid,
    input  busy, rdata, tx_ready
  );

  modport slave (
    input  start, ren, raddr, tx_data, tx_valid,
    output busy, rdata, tx_ready
  );

endinterface

// File: rtl/x_micro_scope_ser.sv
// Word-to-byte serialiser: loads a DATA_W word and presents it LSB byte first on a
// valid/ready stream.
//   i_load  : capture i_word, restart at byte 0 and raise valid
//   i_stop  : end the word early; valid drops after the handshake in progress
//   o_data / o_valid / i_ready : byte stream (all outputs registered)
//   o_hs    : handshake this cycle; o_last : current byte is the word's last
module x_micro_scope_ser #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_word,
  input  logic              i_stop,
  input  logic              i_ready,
  output logic [7:0]        o_data,
  output logic              o_valid,
  output logic              o_hs,
  output logic              o_last
);

  localparam int unsigned NBytes = DATA_W / 8;
  localparam int unsigned IdxW   = (NBytes > 1) ? $clog2(NBytes) : 1;

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              valid_q, valid_d;

  assign o_data  = shift_q[7:0];
  assign o_valid = valid_q;
  assign o_hs    = valid_q & i_ready;
  assign o_last  = (idx_q == IdxW'(NBytes - 1));

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (i_load) begin
      shift_d = i_word;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (o_hs) begin
      shift_d = shift_q >> 8;
      idx_d   = idx_q + IdxW'(1);
      if (o_last || i_stop) valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/x_micro_scope_ctrl.sv
// Sequencer for one x_micro_scope capture/readout cycle: arm, masked trigger, start
// pulse, wait for capture, then read the RAM in address order and stream each word
// LSB byte first.
//   i_clk, i_rst_n            : clock, async active-low reset
//   i_arm, i_abort            : single-cycle host commands
//   i_trig_mask/value, i_probe: trigger compare inputs (probe also feeds the scope)
//   scope                     : scope control/readout port and byte stream (master)
//   o_armed                   : high while waiting for the trigger
//   o_done                    : one-cycle pulse on the cycle IDLE is re-entered
module x_micro_scope_ctrl
  import x_micro_scope_pkg::*;
#(
  parameter int unsigned DATA_W = SCOPE_DATA_W,
  parameter int unsigned ADDR_W = SCOPE_ADDR_W
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_arm,
  input  logic                i_abort,
  input  logic [DATA_W-1:0]   i_trig_mask,
  input  logic [DATA_W-1:0]   i_trig_value,
  input  logic [DATA_W-1:0]   i_probe,
  x_micro_scope_ctrl_if.master scope,
  output logic                o_armed,
  output logic                o_done
);

  // One extra counter bit keeps the terminal compare distinct from the address wrap.
  localparam logic [ADDR_W:0] LastWord = {1'b0, {ADDR_W{1'b1}}};

  scope_ctrl_state_t state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              abort_q, abort_d;
  logic              done_q, done_d;
  logic              abort_any, trig_hit, ser_load, ser_hs, ser_last;
  logic [7:0]        ser_data;
  logic              ser_valid;

  assign abort_any = i_abort | abort_q;
  assign trig_hit  = (((i_probe ^ i_trig_value) & i_trig_mask) == '0);

  assign scope.start    = (state_q == StStart);
  assign scope.ren      = (state_q == StRdReq);
  assign scope.raddr    = cnt_q[ADDR_W-1:0];
  assign scope.tx_data  = ser_data;
  assign scope.tx_valid = ser_valid;
  assign o_armed        = (state_q == StArmed);
  assign o_done         = done_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    abort_d  = abort_q;
    ser_load = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Arm wins over a simultaneous abort; a lone abort in IDLE is dropped.
        abort_d = 1'b0;
        if (i_arm) state_d = StArmed;
      end
      StArmed: begin
        if (i_abort) state_d = StIdle;
        else if (trig_hit) state_d = StStart;
      end
      StStart: begin
        if (i_abort) abort_d = 1'b1;
        state_d = StCapture;
      end
      StCapture: begin
        // The scope cannot be stopped: a pending abort only takes effect at busy fall.
        if (i_abort) abort_d = 1'b1;
        if (!scope.busy) begin
          if (abort_any) begin
            state_d = StIdle;
          end else begin
            state_d = StRdReq;
            cnt_d   = '0;
          end
        end
      end
      StRdReq: begin
        state_d = i_abort ? StIdle : StRdLat;
      end
      StRdLat: begin
        if (i_abort) begin
          state_d = StIdle;
        end else begin
          ser_load = 1'b1;
          state_d  = StSend;
        end
      end
      StSend: begin
        // The byte on the bus always completes its handshake before an abort lands.
        if (i_abort) abort_d = 1'b1;
        if (ser_hs) begin
          if (abort_any) begin
            state_d = StIdle;
          end else if (ser_last) begin
            if (cnt_q == LastWord) begin
              state_d = StIdle;
            end else begin
              cnt_d   = cnt_q + (ADDR_W + 1)'(1);
              state_d = StRdReq;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    done_d = (state_d == StIdle) && (state_q != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      done_q  <= done_d;
    end
  end

  x_micro_scope_ser #(
    .DATA_W (DATA_W)
  ) u_ser (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (ser_load),
    .i_word  (scope.rdata),
    .i_stop  (abort_any),
    .i_ready (scope.tx_ready),
    .o_data  (ser_data),
    .o_valid (ser_valid),
    .o_hs    (ser_hs),
    .o_last  (ser_last)
  );

endmodule
